// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer. Borrows the shared execute-stage ALU
// for every add/subtract step; 37-cycle fixed latency, 1 cycle for divide-by-zero.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0001
`endif

module muldiv_sequencer #(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Start,
  input  logic                 i_Kill,
  input  logic [2:0]           i_Funct3,
  input  logic [WORD_SIZE-1:0] i_Rs1,
  input  logic [WORD_SIZE-1:0] i_Rs2,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic [WORD_SIZE-1:0] o_Result,
  output logic                 o_AluReq,
  output logic [3:0]           o_AluOperation,
  output logic [WORD_SIZE-1:0] o_AluOp1,
  output logic [WORD_SIZE-1:0] o_AluOp2,
  input  logic [WORD_SIZE-1:0] i_AluResult
);

  localparam int CNT_W = $clog2(WORD_SIZE);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_LOOP, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_funct3;
  logic                 r_sign_a, r_sign_b;
  logic [WORD_SIZE-1:0] r_hi, r_lo, r_m;
  logic [CNT_W-1:0]     r_cnt;
  logic [WORD_SIZE-1:0] r_result;
  logic                 r_busy, r_done;

  logic [WORD_SIZE-1:0] w_hi_nxt, w_lo_nxt, w_m_nxt, w_result_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_accept, w_load_result;
  logic                 w_rs1_signed, w_rs2_signed;
  logic                 w_is_div, w_neg_res, w_carry, w_sub_ok;
  logic [WORD_SIZE-1:0] w_s;

  // HI/R, LO/Q and M/D share registers; funct3[2] picks the interpretation.
  assign w_is_div  = r_funct3[2];
  assign w_neg_res = r_sign_a ^ r_sign_b;
  assign w_s       = {r_hi[WORD_SIZE-2:0], r_lo[WORD_SIZE-1]};
  assign w_carry   = (i_AluResult < r_hi);
  assign w_sub_ok  = r_hi[WORD_SIZE-1] | (w_s >= r_m);

  always_comb begin
    w_rs1_signed = 1'b0;
    w_rs2_signed = 1'b0;
    case (i_Funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        w_rs1_signed = 1'b1;
        w_rs2_signed = 1'b1;
      end
      3'b010:  w_rs1_signed = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    o_AluReq       = 1'b0;
    o_AluOperation = `ALU_ADD;
    o_AluOp1       = '0;
    o_AluOp2       = '0;
    case (r_state)
      S_NEG_A: begin
        o_AluReq       = 1'b1;
        o_AluOperation = `ALU_SUB;
        o_AluOp2       = r_lo;
      end
      S_NEG_B: begin
        o_AluReq       = 1'b1;
        o_AluOperation = `ALU_SUB;
        o_AluOp2       = r_m;
      end
      S_LOOP: begin
        o_AluReq = 1'b1;
        if (w_is_div) begin
          o_AluOperation = `ALU_SUB;
          o_AluOp1       = w_s;
          o_AluOp2       = r_m;
        end else begin
          o_AluOp1 = r_hi;
          o_AluOp2 = r_lo[0] ? r_m : '0;
        end
      end
      S_FIX_LO: begin
        o_AluReq       = 1'b1;
        o_AluOperation = `ALU_SUB;
        o_AluOp2       = r_lo;
      end
      S_FIX_HI: begin
        o_AluReq       = 1'b1;
        o_AluOperation = `ALU_SUB;
        o_AluOp2       = r_hi;
      end
      default: ;
    endcase
  end

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_m_nxt       = r_m;
    w_cnt_nxt     = r_cnt;
    w_accept      = 1'b0;
    w_load_result = 1'b0;
    w_result_nxt  = r_result;
    case (r_state)
      S_IDLE: begin
        if (i_Start && !i_Kill) begin
          w_accept  = 1'b1;
          w_hi_nxt  = '0;
          w_lo_nxt  = i_Rs1;
          w_m_nxt   = i_Rs2;
          w_cnt_nxt = '0;
          if (i_Funct3[2] && (i_Rs2 == '0)) begin
            w_load_result = 1'b1;
            w_result_nxt  = i_Funct3[1] ? i_Rs1 : '1;
            w_state_nxt   = S_DONE;
          end else begin
            w_state_nxt = S_NEG_A;
          end
        end
      end
      S_NEG_A: begin
        if (r_sign_a) w_lo_nxt = i_AluResult;
        w_state_nxt = S_NEG_B;
      end
      S_NEG_B: begin
        if (r_sign_b) w_m_nxt = i_AluResult;
        w_cnt_nxt   = '0;
        w_state_nxt = S_LOOP;
      end
      S_LOOP: begin
        if (w_is_div) begin
          if (w_sub_ok) begin
            w_hi_nxt = i_AluResult;
            w_lo_nxt = {r_lo[WORD_SIZE-2:0], 1'b1};
          end else begin
            w_hi_nxt = w_s;
            w_lo_nxt = {r_lo[WORD_SIZE-2:0], 1'b0};
          end
        end else begin
          w_hi_nxt = {w_carry, i_AluResult[WORD_SIZE-1:1]};
          w_lo_nxt = {i_AluResult[0], r_lo[WORD_SIZE-1:1]};
        end
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_ITER) w_state_nxt = S_FIX_LO;
      end
      S_FIX_LO: begin
        if (w_neg_res) w_lo_nxt = i_AluResult;
        w_state_nxt = S_FIX_HI;
      end
      S_FIX_HI: begin
        if (w_is_div) begin
          if (r_sign_a) w_hi_nxt = i_AluResult;
        end else if (w_neg_res) begin
          // LO was already negated, and negation keeps zero at zero, so this
          // still tests whether the borrow propagates into the high word.
          w_hi_nxt = (r_lo == '0) ? i_AluResult : ~r_hi;
        end
        w_load_result = 1'b1;
        w_result_nxt  = ((r_funct3 == 3'b000) || (r_funct3[2:1] == 2'b10)) ? r_lo : w_hi_nxt;
        w_state_nxt   = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_Kill && (r_state != S_IDLE)) begin
      w_state_nxt   = S_IDLE;
      w_load_result = 1'b0;
      w_result_nxt  = r_result;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; all datapath registers are reset, they are
  // plain flops rather than a memory array.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state  <= S_IDLE;
      r_funct3 <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_m     <= w_m_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_funct3 <= i_Funct3;
        r_sign_a <= w_rs1_signed & i_Rs1[WORD_SIZE-1];
        r_sign_b <= w_rs2_signed & i_Rs2[WORD_SIZE-1];
      end
      if (w_load_result) r_result <= w_result_nxt;
    end
  end

  assign o_Busy   = r_busy;
  assign o_Done   = r_done;
  assign o_Result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; models the shared ALU and
// checks per-cycle handshake/ownership plus hand-computed results.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0001
`endif

module tb_muldiv_sequencer;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic        i_Start = 1'b0;
  logic        i_Kill = 1'b0;
  logic [2:0]  i_Funct3 = '0;
  logic [31:0] i_Rs1 = '0;
  logic [31:0] i_Rs2 = '0;
  logic        o_Busy, o_Done, o_AluReq;
  logic [31:0] o_Result, o_AluOp1, o_AluOp2, i_AluResult;
  logic [3:0]  o_AluOperation;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_result = '0;

  muldiv_sequencer #(.WORD_SIZE(32)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Start(i_Start), .i_Kill(i_Kill),
    .i_Funct3(i_Funct3), .i_Rs1(i_Rs1), .i_Rs2(i_Rs2),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Result(o_Result),
    .o_AluReq(o_AluReq), .o_AluOperation(o_AluOperation),
    .o_AluOp1(o_AluOp1), .o_AluOp2(o_AluOp2), .i_AluResult(i_AluResult)
  );

  always #5 i_Clk = ~i_Clk;

  always_comb begin
    i_AluResult = (o_AluOperation == `ALU_SUB) ? (o_AluOp1 - o_AluOp2)
                                               : (o_AluOp1 + o_AluOp2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Cycle k=1 is the cycle right after the edge that samples i_Start.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int poke_k);
    logic [3:0] exp_op;
    @(negedge i_Clk);
    i_Start  = 1'b1;
    i_Funct3 = f3;
    i_Rs1    = a;
    i_Rs2    = b;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge i_Clk);
      if (k >= lat)                               exp_op = `ALU_ADD;
      else if (k >= 3 && k <= 34 && !f3[2])       exp_op = `ALU_ADD;
      else                                        exp_op = `ALU_SUB;
      check({tag, " busy"}, 32'(o_Busy), 32'(k <= lat));
      check({tag, " done"}, 32'(o_Done), 32'(k == lat));
      check({tag, " alureq"}, 32'(o_AluReq), 32'(k < lat));
      check({tag, " aluop"}, 32'(o_AluOperation), 32'(exp_op));
      if (k >= lat) check({tag, " result"}, o_Result, exp);
      i_Start = (k == poke_k);
      if (k == poke_k) begin
        i_Funct3 = 3'b000;
        i_Rs1    = 32'd3;
        i_Rs2    = 32'd3;
      end
    end
    i_Start = 1'b0;
    last_result = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #2;
    check("reset busy", 32'(o_Busy), 32'd0);
    check("reset done", 32'(o_Done), 32'd0);
    check("reset alureq", 32'(o_AluReq), 32'd0);
    check("reset result", o_Result, 32'd0);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;

    run_op("mul_7x6",      3'b000, 32'd7,        32'd6,        32'd42,       37, 0);
    run_op("mul_neg3x5",   3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 37, 0);
    run_op("mulh_min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 37, 0);
    run_op("mulhsu_ones",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 37, 0);
    run_op("mulhu_ones",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 37, 0);
    run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 37, 0);
    run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 37, 0);
    run_op("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       37, 0);
    run_op("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        37, 0);
    run_op("divu_by0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    run_op("rem_by0",      3'b110, 32'd5,        32'd0,        32'd5,        1,  0);
    run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 37, 0);
    run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        37, 0);
    run_op("start_ignored",3'b101, 32'd100,      32'd7,        32'd14,       37, 5);

    // Kill at cycle N+10: back to IDLE at N+11, no done, result untouched.
    @(negedge i_Clk);
    i_Start  = 1'b1;
    i_Funct3 = 3'b000;
    i_Rs1    = 32'd123;
    i_Rs2    = 32'd456;
    for (int k = 1; k <= 10; k++) begin
      @(negedge i_Clk);
      i_Start = 1'b0;
    end
    check("kill busy before", 32'(o_Busy), 32'd1);
    i_Kill = 1'b1;
    @(negedge i_Clk);
    i_Kill = 1'b0;
    check("kill idle busy", 32'(o_Busy), 32'd0);
    check("kill idle alureq", 32'(o_AluReq), 32'd0);
    check("kill result held", o_Result, last_result);
    for (int k = 0; k < 30; k++) begin
      @(negedge i_Clk);
      check("kill no done", 32'(o_Done), 32'd0);
    end
    run_op("kill_restart", 3'b000, 32'd123, 32'd456, 32'd56088, 37, 0);

    // Asynchronous reset mid-operation at cycle N+20.
    @(negedge i_Clk);
    i_Start  = 1'b1;
    i_Funct3 = 3'b101;
    i_Rs1    = 32'd100;
    i_Rs2    = 32'd7;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_Clk);
      i_Start = 1'b0;
    end
    check("rst busy before", 32'(o_Busy), 32'd1);
    i_Rst_n = 1'b0;
    #1;
    check("rst busy", 32'(o_Busy), 32'd0);
    check("rst done", 32'(o_Done), 32'd0);
    check("rst alureq", 32'(o_AluReq), 32'd0);
    check("rst result", o_Result, 32'd0);
    check("rst aluop1", o_AluOp1, 32'd0);
    check("rst aluop2", o_AluOp2, 32'd0);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_Clk);
      check("rst no done", 32'(o_Done), 32'd0);
    end
    last_result = '0;
    run_op("after_rst", 3'b110, 32'd17, 32'hFFFFFFFB, 32'd2, 37, 0);

    @(negedge i_Clk);
    check("idle aluop1", o_AluOp1, 32'd0);
    check("idle aluop2", o_AluOp2, 32'd0);
    check("idle aluop", 32'(o_AluOperation), 32'(`ALU_ADD));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

- Iterative RV32M multiply/divide unit.
- It borrows the shared `ALU` for every add/subtract step instead of owning its own adder.
- It sits beside the execute stage. While `o_AluReq` is high, the execute stage steers the ALU inputs to this block's `o_Alu*` ports and stalls the pipeline on `o_Busy`.
- Fixed latency of 37 cycles; 1 cycle for divide-by-zero.

## Interface
- `WORD_SIZE`, default `` `WORD_SIZE `` (32): operand/result width. RTL is written for 32.
- `i_Clk` in 1: rising-edge clock.
- `i_Rst_n` in 1: asynchronous, active-low reset.
- `i_Start` in 1: start request. Sampled only in IDLE.
- `i_Kill` in 1: synchronous abort (pipeline flush).
- `i_Funct3` in 3: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_Rs1` in 32: multiplicand or dividend.
- `i_Rs2` in 32: multiplier or divisor.
- `o_Busy` in → out 1: high in every state except IDLE.
- `o_Done` out 1: one-cycle pulse; `o_Result` is valid in that cycle.
- `o_Result` out 32: registered result. Held until the next accepted start.
- `o_AluReq` out 1: high while the sequencer owns the ALU (NEG_A through FIX_HI).
- `o_AluOperation` out 4: `` `ALU_ADD `` or `` `ALU_SUB ``.
- `o_AluOp1` out 32: ALU operand 1.
- `o_AluOp2` out 32: ALU operand 2.
- `i_AluResult` in 32: ALU result. Combinational; consumed in the same cycle.

## Operation
**States:** IDLE → NEG_A → NEG_B → LOOP (32 iterations, 5-bit counter) → FIX_LO → FIX_HI → DONE → IDLE.

**Accepting a request**
- In IDLE, `i_Start=1` latches `i_Funct3`, `i_Rs1` and `i_Rs2`.
- Signedness: rs1 is signed for MUL, MULH, MULHSU, DIV and REM. rs2 is signed for MUL, MULH, DIV and REM.
- Sign flags latched at start:
  - Result sign (multiply and quotient) = signA XOR signB.
  - Remainder sign = signA.
- Divide-by-zero (`i_Rs2==0`, funct3[2]=1) skips directly to DONE:
  - DIV/DIVU → `0xFFFFFFFF`.
  - REM/REMU → `i_Rs1`.

**NEG_A / NEG_B**
- ALU performs SUB with Op1=0 and Op2=operand.
- The result replaces the operand only if that operand is signed and negative. This produces magnitudes.

**LOOP, multiply**
- Registers: HI (init 0), LO (init |A|), M = |B|.
- ALU performs ADD with Op1=HI and Op2 = LO[0] ? M : 0.
- carry = (i_AluResult < HI), unsigned compare.
- {HI,LO} ← {carry, i_AluResult, LO} >> 1.

**LOOP, divide** (restoring division)
- Registers: R (init 0), Q (init |A|), D = |B|.
- S = {R[30:0], Q[31]}.
- ALU performs SUB with Op1=S and Op2=D.
- If R[31] | (S >= D): R ← i_AluResult, Q ← {Q[30:0],1}.
- Otherwise: R ← S, Q ← {Q[30:0],0}.

**FIX_LO / FIX_HI** (two's-complement negation when the relevant sign flag is set)
- Multiply:
  - FIX_LO: LO ← 0 − LO via ALU SUB.
  - FIX_HI: HI ← (old LO==0) ? 0 − HI via ALU SUB : ~HI.
- Divide:
  - FIX_LO negates Q using the result sign.
  - FIX_HI negates R using the remainder sign.
- When the flag is clear, the register is unchanged. The state is still visited, so latency stays fixed.

**Result select in DONE**
- MUL → LO.
- MULH/MULHSU/MULHU → HI.
- DIV/DIVU → Q.
- REM/REMU → R.

**Overflow**
- DIV `0x80000000 / 0xFFFFFFFF` → `0x80000000`; REM of the same → 0.
- This falls out of the magnitude algorithm; there is no special case.

**ALU outputs outside ownership:** `o_AluReq=0`, `o_AluOperation=` `` `ALU_ADD ``, `o_AluOp1`/`o_AluOp2` = 0.

## Timing
**Reset (`i_Rst_n=0`, asynchronous)**
- State → IDLE.
- `o_Busy`, `o_Done`, `o_AluReq`, `o_Result`, all internal registers → 0.
- Reset mid-operation discards the operation with no `o_Done`.

**Normal latency**
- Start sampled at edge N.
- NEG_A at N+1, NEG_B at N+2, LOOP at N+3..N+34, FIX_LO at N+35, FIX_HI at N+36.
- DONE at N+37: `o_Done=1`, `o_Result` valid.
- IDLE at N+38, ready to accept a new start in that same cycle.

**Divide-by-zero:** DONE at N+1.

**Start and kill rules**
- `i_Start` while `o_Busy=1` is ignored; no queueing.
- `i_Kill=1` in any non-IDLE state → IDLE at the next edge. No `o_Done`; `o_Result` keeps its previous value.
- `i_Kill` and `i_Start` together in IDLE: kill wins and nothing starts.
- `i_Kill` in DONE: `o_Done` has already pulsed that cycle. The unit returns to IDLE normally.

**Registered outputs:** `o_Result`, `o_Done` and `o_Busy`. All `o_Alu*` outputs are combinational from state.

## Test plan
- **MUL:** MUL 7×6 → `o_Result=42` with `o_Done` exactly at N+37, and `o_Busy` high N+1..N+37.
- **Signed/mixed high half:**
  - MULH `0x80000000`×`0x80000000` → `0x40000000`.
  - MULHSU `0xFFFFFFFF`×`0xFFFFFFFF` → `0xFFFFFFFF`.
  - MULHU `0xFFFFFFFF`×`0xFFFFFFFF` → `0xFFFFFFFE`.
- **Signed divide:**
  - DIV −7/2 → `0xFFFFFFFD`; REM −7/2 → `0xFFFFFFFF`.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- **Zero and overflow:**
  - DIVU 5/0 → `0xFFFFFFFF` at N+1; REM 5/0 → 5 at N+1.
  - DIV `0x80000000`/−1 → `0x80000000`; REM of the same → 0.
- **ALU ownership:** on every cycle of an operation, check `o_AluReq` and that `o_AluOperation` is ADD/SUB as specified. Check `o_AluReq=0` in IDLE and DONE.
- **Abort paths:**
  - Kill at N+10 → IDLE at N+11 with no `o_Done`; an immediate restart then gives the correct result.
  - `i_Rst_n` low at N+20 → all outputs 0 asynchronously.
  - `i_Start` pulsed while busy → ignored, and the original result is unchanged.
